dmem_arbiter: RTL

Two-port arbiter and sequencer sharing the single 256×32 data memory between the instruction-fetch port (port 0) and the load/store port (port 1). Registers each winning request, drives the memory's read/write strobes, address and write data for exactly one access cycle, captures read data and returns a one-cycle acknowledge to the owner. Sits between the CPU front end / MEM stage and the data memory; the only master of the memory's control inputs.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 37 +++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro used by this slice: DMEM_ARB_RR_EN (round-robin arbitration).
package dmem_pkg;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the fetch and load/store ports.
// DMEM_ARB_RR_EN defined: contended grants alternate; otherwise port 1 has fixed priority.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant_id
);

`ifdef DMEM_ARB_RR_EN
    // Contention goes to whichever port did not win last; a lone requester wins outright.
    always_comb begin
        grant_id = PORT_IF;
        if (req0 && req1) begin
            grant_id = ~last_owner;
        end else if (req1) begin
            grant_id = PORT_LS;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_id = PORT_IF;
        if (req1) begin
            grant_id = PORT_LS;
        end
        if (!req0 && !req1) begin
            grant_id = PORT_IF;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer owning the 256x32 data memory: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: port 1 fixed priority).
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t         state_q;
    logic           owner_q;
    logic           we_q;
    logic           oor_q;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic           ack0_q;
    logic           ack1_q;
    logic           busy_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic [AW-1:0]  mem_addr_q;
    logic [31:0]    mem_wdata_q;

    logic           grant_id;
    logic           last_owner;
    logic           sel_we_d;
    logic [31:0]    sel_addr_d;
    logic [31:0]    sel_wdata_d;
    logic           sel_oor_d;

`ifdef DMEM_ARB_RR_EN
    logic           last_q;
    assign last_owner = last_q;
`else
    assign last_owner = PORT_LS;
`endif

    dmem_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner),
        .grant_id   (grant_id)
    );

    assign sel_we_d    = (grant_id == PORT_LS) ? we1    : we0;
    assign sel_addr_d  = (grant_id == PORT_LS) ? addr1  : addr0;
    assign sel_wdata_d = (grant_id == PORT_LS) ? wdata1 : wdata0;
    assign sel_oor_d   = (sel_addr_d >= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= PORT_IF;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            last_q      <= PORT_LS;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        // Strobes, address and data are registered here so they are stable for the whole ACCESS cycle.
                        owner_q     <= grant_id;
                        we_q        <= sel_we_d;
                        oor_q       <= sel_oor_d;
                        mem_read_q  <= ~sel_oor_d & ~sel_we_d;
                        mem_write_q <= ~sel_oor_d &  sel_we_d;
                        mem_addr_q  <= sel_addr_d[AW-1:0];
                        mem_wdata_q <= sel_wdata_d;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_q      <= grant_id;
`endif
                    end
                end
                ACCESS: begin
                    rdata_q     <= (we_q || oor_q) ? 32'h0 : mem_rdata;
                    err_q       <= oor_q;
                    ack0_q      <= (owner_q == PORT_IF);
                    ack1_q      <= (owner_q == PORT_LS);
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= 32'h0;
                    state_q     <= RESP;
                end
                RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset arriving mid-transaction must suppress both the memory write and the acknowledge at once.
    assign mem_write = mem_write_q & ~rst;
    assign ack0      = ack0_q & ~rst;
    assign ack1      = ack1_q & ~rst;

    assign mem_read  = mem_read_q;
    assign mem_addr  = {{(32-AW){1'b0}}, mem_addr_q};
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
